// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined binary mux tree with valid/ready flow control.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_data/in_sel
//   upstream; out_valid/out_ready/out_data/out_sel downstream; occupancy.
module mux_tree_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic [SEL_W:0]          occupancy
);

  localparam int LEVELS = SEL_W;

  logic [LEVELS-1:0] vld;
  logic [LEVELS-1:0] load;

  // A stage loads when empty or when its word moves on; the
  // chain is resolved from the output back so bubbles collapse.
  always_comb begin
    load = '0;
    load[LEVELS-1] = !vld[LEVELS-1] || out_ready;
    for (int k = LEVELS - 2; k >= 0; k--) begin
      load[k] = !vld[k] || load[k+1];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < LEVELS; k++) begin : g_stg
    localparam int N = NUM_IN >> (k + 1);

    logic [2*N*WIDTH-1:0] src;
    logic                 src_v;
    logic [SEL_W-1:0]     src_sel;
    logic [N*WIDTH-1:0]   red;
    logic [N*WIDTH-1:0]   q;
    logic                 v_q;
    logic [SEL_W-1:0]     s_q;

    if (k == 0) begin : g_head
      assign src     = in_data;
      assign src_v   = in_valid;
      assign src_sel = in_sel;
    end else begin : g_body
      assign src     = g_stg[k-1].q;
      assign src_v   = g_stg[k-1].v_q;
      assign src_sel = g_stg[k-1].s_q;
    end

    // Pair (2j, 2j+1) collapses to word j under sel bit k.
    always_comb begin
      red = '0;
      for (int j = 0; j < N; j++) begin
        red[j*WIDTH +: WIDTH] = src_sel[k]
          ? src[(2*j+1)*WIDTH +: WIDTH]
          : src[(2*j)*WIDTH +: WIDTH];
      end
    end

    // Payload only moves with a valid word; an empty load just
    // clears the valid bit and leaves stale data in place.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        q   <= '0;
        s_q <= '0;
      end else if (load[k]) begin
        v_q <= src_v;
        if (src_v) begin
          q   <= red;
          s_q <= src_sel;
        end
      end
    end

    assign vld[k] = v_q;

    if (k == LEVELS - 1) begin : g_out
      assign out_data = q;
      assign out_sel  = s_q;
    end
  end

  assign out_valid = vld[LEVELS-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < LEVELS; k++) begin
      occupancy = occupancy + (SEL_W+1)'(vld[k]);
    end
  end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed tables, corner sequences and a
// randomized queue-model scoreboard for mux_tree_pipe.
module tb_mux_tree_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [SEL_W-1:0]        in_sel = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic [SEL_W:0]          occupancy;

  mux_tree_pipe #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
  endtask

  // Reference: selected word is the channel indexed by sel.
  function automatic logic [7:0] pick(input logic [31:0] d,
                                      input logic [1:0] s);
    return d[s*8 +: 8];
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] data;
    logic [7:0]  exp;
  } vec_t;

  vec_t tab[8];

  // Randomized scoreboard state
  logic       rnd_on = 1'b0;
  logic [9:0] model_q[$];
  logic       hold_prev = 1'b0;
  logic [9:0] prev_out = '0;
  int         n_xfer = 0;

  always @(negedge clk) begin
    if (rnd_on) begin
      chk("rand_occupancy", 32'(occupancy), 32'(model_q.size()));
      if (hold_prev)
        chk("rand_hold", 32'({out_sel, out_data}), 32'(prev_out));
      if (out_valid && out_ready) begin
        if (model_q.size() == 0) begin
          n_total++;
          $display("FAIL rand_spurious: got %0h required none",
                   {out_sel, out_data});
        end else begin
          chk("rand_data", 32'({out_sel, out_data}),
              32'(model_q.pop_front()));
          n_xfer++;
        end
      end
      if (in_valid && in_ready)
        model_q.push_back({in_sel, pick(in_data, in_sel)});
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_sel, out_data};
    end
  end

  initial begin
    int cyc;
    tab[0] = '{2'd0, 32'h4433_2211, 8'h11};
    tab[1] = '{2'd1, 32'h4433_2211, 8'h22};
    tab[2] = '{2'd2, 32'h4433_2211, 8'h33};
    tab[3] = '{2'd3, 32'h4433_2211, 8'h44};
    tab[4] = '{2'd3, 32'hDEAD_BEEF, 8'hDE};
    tab[5] = '{2'd0, 32'hDEAD_BEEF, 8'hEF};
    tab[6] = '{2'd1, 32'hDEAD_BEEF, 8'hBE};
    tab[7] = '{2'd2, 32'hA5C3_0F96, 8'hC3};

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic single word
    out_ready = 1'b1;
    push(32'h4433_2211, 2'd2);
    step();
    in_valid = 1'b0;
    #1;
    chk("basic_occ1", 32'(occupancy), 32'd1);
    chk("basic_early", 32'(out_valid), 32'd0);
    step();
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data", 32'(out_data), 32'h33);
    chk("basic_sel", 32'(out_sel), 32'd2);
    step();
    chk("basic_empty", 32'(occupancy), 32'd0);
    chk("basic_nvalid", 32'(out_valid), 32'd0);

    // Streaming from the table
    for (int i = 0; i < 10; i++) begin
      if (i < 8) push(tab[i].data, tab[i].sel);
      else in_valid = 1'b0;
      #1;
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) begin
        chk("stream_valid", 32'(out_valid), 32'd1);
        chk("stream_data", 32'(out_data), 32'(tab[i-2].exp));
        chk("stream_sel", 32'(out_sel), 32'(tab[i-2].sel));
      end
      step();
    end
    chk("stream_drained", 32'(occupancy), 32'd0);

    // Backpressure
    out_ready = 1'b0;
    push(32'h4433_2211, 2'd0);
    #1;
    chk("bp_rdy0", 32'(in_ready), 32'd1);
    step();
    push(32'h4433_2211, 2'd1);
    #1;
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    step();
    push(32'h4433_2211, 2'd2);
    #1;
    chk("bp_stall", 32'(in_ready), 32'd0);
    chk("bp_occ", 32'(occupancy), 32'd2);
    chk("bp_data", 32'(out_data), 32'h11);
    step();
    chk("bp_still", 32'(in_ready), 32'd0);
    chk("bp_hold", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    #1;
    chk("bp_release", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("bp_d2v", 32'(out_valid), 32'd1);
    chk("bp_d2", 32'(out_data), 32'h22);
    step();
    chk("bp_d3", 32'(out_data), 32'h33);
    chk("bp_d3s", 32'(out_sel), 32'd2);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Bubble collapse
    out_ready = 1'b0;
    push(32'hDEAD_BEEF, 2'd3);
    step();
    in_valid = 1'b0;
    step();
    #1;
    chk("bub_occ", 32'(occupancy), 32'd1);
    chk("bub_valid", 32'(out_valid), 32'd1);
    chk("bub_ready", 32'(in_ready), 32'd1);
    push(32'hDEAD_BEEF, 2'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("bub_occ2", 32'(occupancy), 32'd2);
    chk("bub_full", 32'(in_ready), 32'd0);
    chk("bub_data", 32'(out_data), 32'hDE);

    // Async reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_occ", 32'(occupancy), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    push(32'hA5C3_0F96, 2'd3);
    step();
    in_valid = 1'b0;
    step();
    chk("arst_new_valid", 32'(out_valid), 32'd1);
    chk("arst_new_data", 32'(out_data), 32'hA5);
    chk("arst_new_sel", 32'(out_sel), 32'd3);
    step();
    chk("arst_new_empty", 32'(occupancy), 32'd0);

    // Randomized run against the queue model
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    rnd_on = 1'b1;
    cyc = 0;
    while (n_xfer < 10000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 4) != 0);
      in_data   = $urandom;
      in_sel    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    if (n_xfer < 10000) begin
      n_total++;
      $display("FAIL rand_timeout: got %0d transfers required 10000",
               n_xfer);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    rnd_on = 1'b0;
    chk("rand_drain", 32'(model_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
